grand_query_sched: RTL and testbench
====================================

# grand_query_sched

Clocked query scheduler for the soft GRAND decoder: accepts one received word plus a reliability permutation, walks error patterns in the decoder's fixed guess order, applies each through the permutation, and checks the candidate against the codebook. One query per cycle. Replaces the delay-driven guess loop with a synthesizable valid/ready block between the channel front-end and the codeword consumer.

## Interface
- `WIDTH`, 8 — codeword length; 7 or 8 supported (codebooks exist only for these).
- `MAX_QUERIES`, 2**WIDTH — query budget, used only when abandonment is compiled in; range 1..2**WIDTH.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — `chat`/`perm` valid.
- `in_ready` out 1 — block can accept; high only in IDLE.
- `chat` in WIDTH — received hard-decision word.
- `perm` in WIDTH*$clog2(WIDTH) — field r = bit position of reliability rank r, rank 0 least reliable, 0-based.
- `out_valid` out 1 — result valid.
- `out_ready` in 1 — consumer accepts.
- `c_out` out WIDTH — decoded codeword.
- `err_out` out WIDTH — error vector applied: `c_out = chat ^ err_out`.
- `n_queries` out WIDTH+1 — queries made, including the hit.
- `abandoned` out 1 — budget exhausted, no hit.

## Operation
- States: IDLE, QUERY, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `chat` and `perm`, clear the rank pattern p to 0 and the counter to 0, then go to QUERY.
- QUERY, each cycle:
  - e[perm[r]] = p[r]; cand = chat ^ e.
  - Counter increments.
  - If cand is in the codebook: register `c_out`=cand, `err_out`=e, `n_queries`=counter+1, `abandoned`=0, go to DONE.
  - Otherwise p ← next(p).
- next(p), over ranks 0..WIDTH-1:
  - If the highest set rank is not WIDTH-1, move that 1 up one rank.
  - Else, if some pair p[i]=1, p[i+1]=0 exists, take the highest such i. Clear i, set i+1, and pack all ones above i+1 contiguously starting at i+2.
  - Else, weight w+1 ones packed at ranks 0..w.
  - Result order: 0, then weight 1, weight 2, and so on; within a weight, rightmost-first.
- No-hit exhaustion is impossible without abandonment: e=chat always yields the all-zero codeword.
- Codebook membership: combinational compare against the 16-entry table for WIDTH.
- DONE: outputs held stable while `out_valid`=1. On `out_ready`, go to IDLE.
- Non-permutation `perm` is illegal input; behaviour is unspecified.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `c_out`=0, `err_out`=0, `n_queries`=0, `abandoned`=0, state IDLE.
- Accept at edge T. Query k is evaluated in cycle T+k. A hit on query k gives `out_valid` from cycle T+k+1.
- `out_ready` may be high before `out_valid`. The handshake completes on the first edge where both are high.
- `in_ready` returns the cycle after the output handshake. There is no accept in the same cycle as output release.
- `in_valid` is ignored outside IDLE.
- `rst_n` low in any state clears immediately (asynchronous) to reset values. Any in-flight query is discarded.
- Counter saturates and never wraps; it is WIDTH+1 bits wide.

## Configuration
- `GRAND_ABANDON_EN` defined:
  - If query MAX_QUERIES misses, go to DONE with `abandoned`=1, `c_out`=chat, `err_out`=0, `n_queries`=MAX_QUERIES.
- `GRAND_ABANDON_EN` undefined:
  - No budget; `abandoned` is tied 0 and `MAX_QUERIES` is ignored.

## Structure
- Package `grand_pkg`:
  - Codebook tables for WIDTH 7 and 8.
  - State enum.
  - Function `is_codeword`.
  - Localparam for the perm field width.
- Sub-module `grand_pattern_step`: combinational next(p) over WIDTH. It is reusable by other GRAND variants.

## Test plan
All cases use WIDTH=8.
- `chat`=00010111, identity perm → `c_out`=00010111, `err_out`=0, `n_queries`=1, `out_valid` at T+2.
- `chat`=00010110, identity perm → `c_out`=00010111, `err_out`=00000001, `n_queries`=2.
- `chat`=00010110, reversed perm (rank r = bit 7−r) → `err_out`=00000001, `n_queries`=9, `out_valid` at T+10.
- With `GRAND_ABANDON_EN` and MAX_QUERIES=4, same as the previous case → `abandoned`=1, `c_out`=00010110, `err_out`=0, `n_queries`=4.
- `out_ready` held low 5 cycles after `out_valid` → outputs stable, `in_ready`=0. Raise `out_ready` → `in_ready`=1 the next cycle.
- `rst_n` pulsed low during QUERY → all outputs at reset values immediately, no `out_valid`. A new accept after release decodes normally.

Source files
------------

// File: rtl/grand_pkg.sv
// Shared types, codebooks and membership check for the soft GRAND query scheduler.
package grand_pkg;

    localparam int unsigned PERM_W  = 3;
    localparam int unsigned CB_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUERY,
        ST_DONE
    } state_e;

    // Extended Hamming [8,4,4]: data in [7:4], parity in [3:0]
    localparam logic [7:0] CODEBOOK8 [CB_SIZE] = '{
        8'h00, 8'h17, 8'h2B, 8'h3C, 8'h4D, 8'h5A, 8'h66, 8'h71,
        8'h8E, 8'h99, 8'hA5, 8'hB2, 8'hC3, 8'hD4, 8'hE8, 8'hFF
    };

    // Hamming [7,4,3]: data in [6:3], parity in [2:0]
    localparam logic [6:0] CODEBOOK7 [CB_SIZE] = '{
        7'h00, 7'h0B, 7'h15, 7'h1E, 7'h26, 7'h2D, 7'h33, 7'h38,
        7'h47, 7'h4C, 7'h52, 7'h59, 7'h61, 7'h6A, 7'h74, 7'h7F
    };

    function automatic logic is_codeword(input logic [7:0] word, input int unsigned width);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < CB_SIZE; i++) begin
            if (width == 7) begin
                if (word == {1'b0, CODEBOOK7[i]}) hit = 1'b1;
            end else begin
                if (word == CODEBOOK8[i]) hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/grand_query_sched_step.sv
// grand_pattern_step: combinational successor of a rank pattern in GRAND guess order
// (weight-ascending, lexicographic on set ranks within a weight).
module grand_pattern_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] p_next
);

    int unsigned hi;
    int unsigned pair_i;
    int unsigned above;
    int unsigned weight;
    logic        any_set;
    logic        pair_found;

    always_comb begin
        hi         = 0;
        pair_i     = 0;
        above      = 0;
        weight     = 0;
        any_set    = 1'b0;
        pair_found = 1'b0;
        p_next     = '0;

        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (p[i]) begin
                any_set = 1'b1;
                hi      = i;
                weight  = weight + 1;
            end
        end
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            if (p[i] && !p[i+1]) begin
                pair_found = 1'b1;
                pair_i     = i;
            end
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (p[i] && (i >= pair_i + 2)) above = above + 1;
        end

        if (!any_set) begin
            p_next[0] = 1'b1;
        end else if (hi != WIDTH - 1) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i == hi)          p_next[i] = 1'b0;
                else if (i == hi + 1) p_next[i] = 1'b1;
                else                  p_next[i] = p[i];
            end
        end else if (pair_found) begin
            // Ones above the moved bit collapse down to sit right behind it
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i < pair_i)                                  p_next[i] = p[i];
                else if (i == pair_i + 1)                        p_next[i] = 1'b1;
                else if (i >= pair_i + 2 && i < pair_i + 2 + above) p_next[i] = 1'b1;
                else                                             p_next[i] = 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                p_next[i] = (i <= weight);
            end
        end
    end

endmodule

// File: rtl/grand_query_sched.sv
// Soft GRAND query scheduler: one codebook query per cycle over the reliability-permuted guess order.
// Optional query budget/abandonment compiled in with `define GRAND_ABANDON_EN.
module grand_query_sched
    import grand_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_QUERIES = 2**WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               chat,
    input  logic [WIDTH*$clog2(WIDTH)-1:0] perm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               c_out,
    output logic [WIDTH-1:0]               err_out,
    output logic [WIDTH:0]                 n_queries,
    output logic                           abandoned
);

    localparam int unsigned PW = $clog2(WIDTH);
    localparam int unsigned CW = WIDTH + 1;

    if ((WIDTH != 7 && WIDTH != 8) || PW != PERM_W) begin : g_bad_width
        $error("grand_query_sched: WIDTH must be 7 or 8");
    end
    if (MAX_QUERIES < 1 || MAX_QUERIES > 2**WIDTH) begin : g_bad_budget
        $error("grand_query_sched: MAX_QUERIES out of range");
    end

    state_e              state_q,  state_d;
    logic [WIDTH-1:0]    chat_q,   chat_d;
    logic [WIDTH*PW-1:0] perm_q,   perm_d;
    logic [WIDTH-1:0]    p_q,      p_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [WIDTH-1:0]    c_out_q,  c_out_d;
    logic [WIDTH-1:0]    err_q,    err_d;
    logic [CW-1:0]       nq_q,     nq_d;
`ifdef GRAND_ABANDON_EN
    logic                ab_q,     ab_d;
`endif

    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] e_vec;
    logic [WIDTH-1:0] cand;
    logic [7:0]       cand8;
    logic             hit;
    logic [CW-1:0]    cnt_inc;

    grand_pattern_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .p_next (p_next)
    );

    always_comb begin : query_datapath
        e_vec = '0;
        // Scatter rank bits to codeword positions; written as a search to avoid a variable index
        for (int unsigned b = 0; b < WIDTH; b++) begin
            for (int unsigned r = 0; r < WIDTH; r++) begin
                if (perm_q[r*PW +: PW] == PW'(b)) e_vec[b] = p_q[r];
            end
        end
        cand               = chat_q ^ e_vec;
        cand8              = '0;
        cand8[WIDTH-1:0]   = cand;
        hit                = is_codeword(cand8, WIDTH);
        cnt_inc            = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        chat_d  = chat_q;
        perm_d  = perm_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        c_out_d = c_out_q;
        err_d   = err_q;
        nq_d    = nq_q;
`ifdef GRAND_ABANDON_EN
        ab_d    = ab_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    chat_d  = chat;
                    perm_d  = perm;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                cnt_d = cnt_inc;
                if (hit) begin
                    c_out_d = cand;
                    err_d   = e_vec;
                    nq_d    = cnt_inc;
`ifdef GRAND_ABANDON_EN
                    ab_d    = 1'b0;
`endif
                    state_d = ST_DONE;
                end
`ifdef GRAND_ABANDON_EN
                else if (cnt_inc == CW'(MAX_QUERIES)) begin
                    c_out_d = chat_q;
                    err_d   = '0;
                    nq_d    = CW'(MAX_QUERIES);
                    ab_d    = 1'b1;
                    state_d = ST_DONE;
                end
`endif
                else begin
                    p_d = p_next;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chat_q  <= '0;
            perm_q  <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            c_out_q <= '0;
            err_q   <= '0;
            nq_q    <= '0;
`ifdef GRAND_ABANDON_EN
            ab_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            chat_q  <= chat_d;
            perm_q  <= perm_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            c_out_q <= c_out_d;
            err_q   <= err_d;
            nq_q    <= nq_d;
`ifdef GRAND_ABANDON_EN
            ab_q    <= ab_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign c_out     = c_out_q;
    assign err_out   = err_q;
    assign n_queries = nq_q;
`ifdef GRAND_ABANDON_EN
    assign abandoned = ab_q;
`else
    assign abandoned = 1'b0;
`endif

endmodule

// File: tb/tb_grand_query_sched.sv
// Self-checking bench for grand_query_sched (WIDTH=8); honours GRAND_ABANDON_EN with a budget of 4.
module tb_grand_query_sched;

    localparam int W = 8;
`ifdef GRAND_ABANDON_EN
    localparam int MQ = 4;
    localparam bit AB = 1'b1;
`else
    localparam int MQ = 256;
    localparam bit AB = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  chat     = '0;
    logic [23:0] perm     = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  c_out;
    logic [7:0]  err_out;
    logic [8:0]  n_queries;
    logic        abandoned;

    grand_query_sched #(.WIDTH(W), .MAX_QUERIES(MQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .chat      (chat),
        .perm      (perm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .err_out   (err_out),
        .n_queries (n_queries),
        .abandoned (abandoned)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] e;
        logic [8:0] n;
        logic       ab;
    } res_t;

    // Codeword iff re-encoding the data nibble from the generator rows reproduces the word
    function automatic logic cw_ok(input logic [7:0] w);
        logic [7:0] g;
        g = '0;
        if (w[4]) g = g ^ 8'h17;
        if (w[5]) g = g ^ 8'h2B;
        if (w[6]) g = g ^ 8'h4D;
        if (w[7]) g = g ^ 8'h8E;
        return g == w;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Guess order = by weight, then lexicographic on set ranks == descending bit-reversed value
    function automatic res_t model(input logic [7:0] ch, input logic [23:0] pm);
        res_t       r;
        int         q;
        logic [7:0] p, e, cand;
        logic [2:0] pos;
        r = '0;
        q = 0;
        for (int w = 0; w <= 8; w++) begin
            for (int v = 255; v >= 0; v--) begin
                if ($countones(8'(v)) == w) begin
                    p = bitrev8(8'(v));
                    e = '0;
                    for (int k = 0; k < 8; k++) begin
                        if (p[k]) begin
                            pos    = pm[k*3 +: 3];
                            e[pos] = 1'b1;
                        end
                    end
                    cand = ch ^ e;
                    q++;
                    if (cw_ok(cand)) begin
                        r.c = cand; r.e = e; r.n = 9'(q); r.ab = 1'b0;
                        return r;
                    end
                    if (AB && q == MQ) begin
                        r.c = ch; r.e = '0; r.n = 9'(MQ); r.ab = 1'b1;
                        return r;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] mkperm(input logic [31:0] nib);
        logic [23:0] pm;
        for (int r = 0; r < 8; r++) pm[r*3 +: 3] = nib[r*4 +: 3];
        return pm;
    endfunction

    typedef enum {M_IDLE, M_QUERY, M_DONE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_left  = 0;
    res_t    m_exp   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (in_valid) begin
                    m_exp   <= model(chat, perm);
                    m_left  <= 1;
                    m_state <= M_QUERY;
                end
                M_QUERY: begin
                    if (m_left == int'(m_exp.n)) m_state <= M_DONE;
                    else                         m_left  <= m_left + 1;
                end
                M_DONE: if (out_ready) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready",  32'(in_ready),  32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_c_out",     32'(c_out),     32'd0);
            check("rst_err_out",   32'(err_out),   32'd0);
            check("rst_n_queries", 32'(n_queries), 32'd0);
            check("rst_abandoned", 32'(abandoned), 32'd0);
        end else begin
            check("in_ready",  32'(in_ready),  32'(m_state == M_IDLE));
            check("out_valid", 32'(out_valid), 32'(m_state == M_DONE));
            if (m_state == M_DONE) begin
                check("c_out",     32'(c_out),     32'(m_exp.c));
                check("err_out",   32'(err_out),   32'(m_exp.e));
                check("n_queries", 32'(n_queries), 32'(m_exp.n));
                check("abandoned", 32'(abandoned), 32'(m_exp.ab));
            end
        end
    end

    task automatic send(input logic [7:0] ch, input logic [23:0] pm);
        @(posedge clk);
        #1;
        chat     = ch;
        perm     = pm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) return;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_handshake();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] ch, input logic [23:0] pm);
        int lat;
        send(ch, pm);
        wait_valid(lat);
        finish_handshake();
    endtask

    task automatic run_case(input string nm, input logic [7:0] ch, input logic [23:0] pm,
                            input logic [7:0] xc, input logic [7:0] xe, input int xn,
                            input logic xab, input int xlat);
        int lat;
        send(ch, pm);
        wait_valid(lat);
        check({nm, "_c"},   32'(c_out),     32'(xc));
        check({nm, "_e"},   32'(err_out),   32'(xe));
        check({nm, "_n"},   32'(n_queries), 32'(xn));
        check({nm, "_ab"},  32'(abandoned), 32'(xab));
        check({nm, "_lat"}, 32'(lat),       32'(xlat));
        finish_handshake();
    endtask

    logic [23:0] id_p, rev_p, s1_p, s2_p;
    int          lat0;

    initial begin
        id_p  = mkperm(32'h76543210);
        rev_p = mkperm(32'h01234567);
        s1_p  = mkperm(32'h35170642);
        s2_p  = mkperm(32'h62047153);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_case("exact", 8'b00010111, id_p, 8'b00010111, 8'h00, 1, 1'b0, 2);
        run_case("flip0", 8'b00010110, id_p, 8'b00010111, 8'b00000001, 2, 1'b0, 3);
`ifdef GRAND_ABANDON_EN
        run_case("rev_abandon", 8'b00010110, rev_p, 8'b00010110, 8'h00, 4, 1'b1, 5);
`else
        run_case("rev", 8'b00010110, rev_p, 8'b00010111, 8'b00000001, 9, 1'b0, 10);
`endif

        run_vec(8'hFF, id_p);
        run_vec(8'h00, s1_p);
        run_vec(8'h96, id_p);
        run_vec(8'h03, s1_p);
        run_vec(8'h81, s2_p);
        run_vec(8'hDB, rev_p);
        run_vec(8'h5B, s2_p);

        // Consumer stall, with a second word offered while busy
        out_ready = 1'b0;
        send(8'h17, id_p);
        wait_valid(lat0);
        chat     = 8'hFF;
        perm     = id_p;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_c_out",    32'(c_out),    32'h17);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat0);
        check("after_stall_c", 32'(c_out),     32'hFF);
        check("after_stall_n", 32'(n_queries), 32'd1);
        finish_handshake();

        // Asynchronous reset in the middle of a query walk
        send(8'b00010110, rev_p);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_c_out",     32'(c_out),     32'd0);
        check("arst_n_queries", 32'(n_queries), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_result", 32'(out_valid), 32'd0);
        run_case("post_rst", 8'b00010110, id_p, 8'b00010111, 8'b00000001, 2, 1'b0, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
